// File: rtl/cont_pkg.sv
// Shared constants and FSM state type for the cont_* counter family.
package cont_pkg;

  localparam logic CNT_WRAP    = 1'b0;
  localparam logic CNT_ONESHOT = 1'b1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } cnt_state_t;

endpackage

// File: rtl/cont_next_val.sv
// Combinational next-count and terminal detect for a modulo-MODULO up/down counter.
module cont_next_val #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_down,
  output logic [WIDTH-1:0] nxt,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 1);

  // Explicit wrap at the terminal value keeps Q inside 0..MODULO-1 for non-power-of-two moduli.
  always_comb begin
    if (up_down) begin
      at_term = (q == MAXV);
      nxt     = at_term ? '0 : q + WIDTH'(1);
    end else begin
      at_term = (q == '0);
      nxt     = at_term ? MAXV : q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/cont_nbits_updown.sv
// WIDTH-bit modulo-MODULO up/down counter with saturating load, wrap/one-shot modes and TC.
module cont_nbits_updown
  import cont_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             done
);

  if (WIDTH < 1 || MODULO < 2 || MODULO > 2 ** WIDTH) begin : g_param_check
    $error("cont_nbits_updown: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULO - 1);

  cnt_state_t       state;
  logic [WIDTH-1:0] nxt;
  logic             at_term;
  logic [WIDTH-1:0] load_val;

  cont_next_val #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_next (
    .q       (Q),
    .up_down (up_down),
    .nxt     (nxt),
    .at_term (at_term)
  );

  assign load_val = ({1'b0, d} >= MOD_EXT) ? MAXV : d;
  assign TC       = enable & at_term & (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      Q     <= '0;
      done  <= 1'b0;
      state <= ST_RUN;
    end else if (load) begin
      Q     <= load_val;
      done  <= 1'b0;
      state <= ST_RUN;
    end else if (enable && state == ST_RUN) begin
      if (at_term && mode == CNT_ONESHOT) begin
        state <= ST_HALT;
        done  <= 1'b1;
      end else begin
        Q <= nxt;
      end
    end
  end

endmodule

// File: tb/tb_cont_nbits_updown.sv
// Randomised and directed check of cont_nbits_updown against an arithmetic reference model.
module tb_cont_nbits_updown;

  localparam int M = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0, enable = 1'b0, up_down = 1'b1, mode = 1'b0, load = 1'b0;
  logic [3:0] d = '0;
  logic [3:0] q;
  logic       tc, done;

  logic       c_reset = 1'b0;
  logic [3:0] qa, qb, dz;
  logic       tca, tcb, donea, doneb, one, zero;

  int errors = 0;
  int checks = 0;

  int mq = 0;
  bit mhalt = 1'b0;
  bit known = 1'b0;

  always #5 clk = ~clk;

  assign one  = 1'b1;
  assign zero = 1'b0;
  assign dz   = '0;

  cont_nbits_updown #(.WIDTH(4), .MODULO(M)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .mode(mode),
    .load(load), .d(d), .Q(q), .TC(tc), .done(done)
  );

  cont_nbits_updown #(.WIDTH(4), .MODULO(16)) u_lo (
    .clk(clk), .reset(c_reset), .enable(one), .up_down(one), .mode(zero),
    .load(zero), .d(dz), .Q(qa), .TC(tca), .done(donea)
  );

  cont_nbits_updown #(.WIDTH(4), .MODULO(16)) u_hi (
    .clk(clk), .reset(c_reset), .enable(tca), .up_down(one), .mode(zero),
    .load(zero), .d(dz), .Q(qb), .TC(tcb), .done(doneb)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check TC before the edge, Q/done after it.
  task automatic cyc(input logic r, input logic l, input logic e, input logic ud,
                     input logic m, input logic [3:0] dv);
    int term;
    reset = r; load = l; enable = e; up_down = ud; mode = m; d = dv;
    #1;
    term = ud ? M - 1 : 0;
    if (known) chk("tc", int'(tc), int'(e && !mhalt && mq == term));
    @(posedge clk);
    if (r) begin
      mq = 0; mhalt = 1'b0;
    end else if (l) begin
      mq = (int'(dv) >= M) ? M - 1 : int'(dv); mhalt = 1'b0;
    end else if (e && !mhalt) begin
      if (mq == term && m) mhalt = 1'b1;
      else mq = ud ? (mq + 1) % M : (mq + M - 1) % M;
    end
    known = 1'b1;
    @(negedge clk);
    chk("q", int'(q), mq);
    chk("done", int'(done), int'(mhalt));
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 1, 0, 0);
    chk("reset_q", int'(q), 0);

    for (int i = 0; i < 11; i++) cyc(0, 0, 1, 1, 0, 0);
    chk("wrap_up", int'(q), 1);
    cyc(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0);
    chk("wrap_down", int'(q), 6);

    cyc(0, 1, 0, 1, 1, 7);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 1, 0);
    chk("halt_q", int'(q), 9);
    chk("halt_done", int'(done), 1);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 1, 2);
    chk("reload", int'(q), 2);
    cyc(0, 0, 1, 1, 1, 0);

    cyc(0, 1, 0, 1, 0, 12);
    chk("sat", int'(q), 9);
    cyc(0, 1, 1, 1, 0, 4);
    chk("load_en", int'(q), 4);

    cyc(0, 0, 1, 1, 0, 0);
    cyc(1, 0, 1, 1, 0, 0);
    cyc(0, 1, 0, 1, 1, 8);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 1, 0);
    cyc(1, 0, 1, 1, 1, 0);
    chk("rst_halt_done", int'(done), 0);
    cyc(1, 1, 1, 1, 0, 6);
    chk("rst_load", int'(q), 0);

    for (int i = 0; i < 300; i++) begin
      cyc(($urandom % 50) == 0, ($urandom % 12) == 0, ($urandom % 4) != 0,
          ($urandom % 3) != 0, ($urandom % 8) < 3, 4'($urandom % 16));
    end

    c_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c_reset = 1'b0;
    for (int k = 0; k < 300; k++) begin
      chk("cascade", int'({qb, qa}), k % 256);
      @(posedge clk);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
